// File: rtl/d_port_arbiter.sv
// Arbitrates the memory data port between the cache and a DMA engine.
// One request at a time; a transfer takes MEM_LAT+2 cycles from acceptance to ready.
module d_port_arbiter #(
  parameter int WORD_SIZE  = 16,
  parameter int FETCH_SIZE = 64,
  parameter int MEM_LAT    = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  c_readM,
  input  logic                  c_writeM,
  input  logic [WORD_SIZE-1:0]  c_address,
  input  logic [FETCH_SIZE-1:0] c_wdata,
  output logic [FETCH_SIZE-1:0] c_rdata,
  output logic                  c_ready,
  output logic                  c_stall,
  input  logic                  dma_br,
  output logic                  dma_bg,
  input  logic                  dma_readM,
  input  logic                  dma_writeM,
  input  logic [WORD_SIZE-1:0]  dma_address,
  input  logic [FETCH_SIZE-1:0] dma_wdata,
  output logic [FETCH_SIZE-1:0] dma_rdata,
  output logic                  dma_ready,
  output logic                  m_readM,
  output logic                  m_writeM,
  output logic [WORD_SIZE-1:0]  m_address,
  output logic [FETCH_SIZE-1:0] m_wdata,
  input  logic [FETCH_SIZE-1:0] m_rdata
);

  localparam int CW = $clog2(MEM_LAT + 1);

  typedef enum logic [2:0] {IDLE, C_BUSY, C_DONE, D_GRANT, D_BUSY, D_DONE} state_t;

  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic          r_lastDma;
  logic          r_isWrite;

  logic w_cReq;
  logic w_dReq;
  logic w_lastBeat;
  logic w_cDoneNext;

  assign w_cReq      = c_readM | c_writeM;
  assign w_dReq      = dma_readM | dma_writeM;
  assign w_lastBeat  = (r_cnt == CW'(MEM_LAT));
  assign w_cDoneNext = (r_state == C_BUSY) && w_lastBeat;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_lastDma <= 1'b1;
      r_isWrite <= 1'b0;
      c_rdata   <= '0;
      c_ready   <= 1'b0;
      c_stall   <= 1'b0;
      dma_bg    <= 1'b0;
      dma_rdata <= '0;
      dma_ready <= 1'b0;
      m_readM   <= 1'b0;
      m_writeM  <= 1'b0;
      m_address <= '0;
      m_wdata   <= '0;
    end else begin
      // Strobes and ready are single-cycle pulses unless re-asserted below.
      m_readM   <= 1'b0;
      m_writeM  <= 1'b0;
      c_ready   <= 1'b0;
      dma_ready <= 1'b0;
      c_stall   <= w_cReq & ~w_cDoneNext;
      case (r_state)
        IDLE: begin
          if (w_cReq && (!dma_br || r_lastDma)) begin
            r_state   <= C_BUSY;
            r_cnt     <= '0;
            r_lastDma <= 1'b0;
            r_isWrite <= c_writeM;
            m_writeM  <= c_writeM;
            m_readM   <= ~c_writeM;
            m_address <= c_address;
            m_wdata   <= c_wdata;
          end else if (dma_br) begin
            r_state <= D_GRANT;
            dma_bg  <= 1'b1;
          end
        end
        C_BUSY: begin
          if (w_lastBeat) begin
            if (!r_isWrite) c_rdata <= m_rdata;
            c_ready <= 1'b1;
            r_state <= C_DONE;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        C_DONE: begin
          if (dma_br) begin
            r_state <= D_GRANT;
            dma_bg  <= 1'b1;
          end else begin
            r_state <= IDLE;
          end
        end
        D_GRANT: begin
          if (!dma_br) begin
            r_state <= IDLE;
            dma_bg  <= 1'b0;
          end else if (w_dReq) begin
            r_state   <= D_BUSY;
            r_cnt     <= '0;
            r_lastDma <= 1'b1;
            r_isWrite <= dma_writeM;
            m_writeM  <= dma_writeM;
            m_readM   <= ~dma_writeM;
            m_address <= dma_address;
            m_wdata   <= dma_wdata;
          end
        end
        D_BUSY: begin
          if (w_lastBeat) begin
            if (!r_isWrite) dma_rdata <= m_rdata;
            dma_ready <= 1'b1;
            r_state   <= D_DONE;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        D_DONE: begin
          if (dma_br) begin
            r_state <= D_GRANT;
          end else begin
            r_state <= IDLE;
            dma_bg  <= 1'b0;
          end
        end
        default: begin
          r_state <= IDLE;
          dma_bg  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_d_port_arbiter.sv
// Scoreboard bench for d_port_arbiter: cache/DMA transfers against a fixed-latency memory model.
// Expected completions are queued when a request is driven and popped when ready pulses.
module tb_d_port_arbiter;

  localparam int MEM_LAT = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        c_readM, c_writeM;
  logic [15:0] c_address;
  logic [63:0] c_wdata, c_rdata;
  logic        c_ready, c_stall;
  logic        dma_br, dma_bg, dma_readM, dma_writeM;
  logic [15:0] dma_address;
  logic [63:0] dma_wdata, dma_rdata;
  logic        dma_ready;
  logic        m_readM, m_writeM;
  logic [15:0] m_address;
  logic [63:0] m_wdata, m_rdata;

  typedef struct {
    logic [15:0] addr;
    logic [63:0] data;
  } exp_t;

  exp_t cExp[$];
  exp_t dExp[$];

  int testsRun = 0;
  int testsFailed = 0;

  logic [63:0] memData;
  int          memCnt;
  bit          memActive;

  d_port_arbiter #(.WORD_SIZE(16), .FETCH_SIZE(64), .MEM_LAT(MEM_LAT)) dut (
    .clk(clk), .reset(reset),
    .c_readM(c_readM), .c_writeM(c_writeM), .c_address(c_address), .c_wdata(c_wdata),
    .c_rdata(c_rdata), .c_ready(c_ready), .c_stall(c_stall),
    .dma_br(dma_br), .dma_bg(dma_bg), .dma_readM(dma_readM), .dma_writeM(dma_writeM),
    .dma_address(dma_address), .dma_wdata(dma_wdata), .dma_rdata(dma_rdata), .dma_ready(dma_ready),
    .m_readM(m_readM), .m_writeM(m_writeM), .m_address(m_address), .m_wdata(m_wdata),
    .m_rdata(m_rdata)
  );

  always #5 clk = ~clk;

  // Memory returns data only during T4 (MEM_LAT cycles after the read strobe); junk otherwise.
  always @(negedge clk) begin
    if (reset) begin
      memActive = 1'b0;
    end else if (m_readM) begin
      memActive = 1'b1;
      memCnt = 0;
    end else if (memActive) begin
      memCnt++;
      if (memCnt > MEM_LAT) memActive = 1'b0;
    end
    m_rdata = (memActive && memCnt == MEM_LAT) ? memData : 64'hBAD0_BAD0_BAD0_BAD0;
  end

  function automatic logic [213:0] allOutputs();
    return {c_rdata, c_ready, c_stall, dma_bg, dma_rdata, dma_ready,
            m_readM, m_writeM, m_address, m_wdata};
  endfunction

  task automatic applyStimulus(input logic rd, input logic wr, input logic [15:0] addr,
                               input logic [63:0] wdata);
    c_readM = rd;
    c_writeM = wr;
    c_address = addr;
    c_wdata = wdata;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    applyStimulus(1'b0, 1'b0, 16'h0, 64'h0);
    dma_br = 1'b0; dma_readM = 1'b0; dma_writeM = 1'b0;
    dma_address = 16'h0; dma_wdata = 64'h0;
    memData = 64'h0;
    m_rdata = 64'h0;
    @(negedge clk);
    @(negedge clk);
    testsRun++;
    if (allOutputs() !== '0) begin
      testsFailed++;
      $display("[TB] FAIL reset_outputs: got %h expected 0", allOutputs());
    end
    reset = 1'b0;
    @(negedge clk);
    testsRun++;
    if (dma_bg !== 1'b0 || c_stall !== 1'b0 || m_readM !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL idle_after_reset: bg=%b stall=%b m_readM=%b expected 0", dma_bg, c_stall, m_readM);
    end
  endtask

  task automatic test_cache_read;
    exp_t e;
    memData = 64'h1111_2222_3333_4444;
    applyStimulus(1'b1, 1'b0, 16'h0020, 64'h0);
    cExp.push_back('{addr: 16'h0020, data: 64'h1111_2222_3333_4444});
    @(negedge clk);
    testsRun++;
    if (m_readM !== 1'b1 || m_writeM !== 1'b0 || m_address !== 16'h0020) begin
      testsFailed++;
      $display("[TB] FAIL read_issue: rd=%b wr=%b addr=%h expected 1 0 0020", m_readM, m_writeM, m_address);
    end
    testsRun++;
    if (c_stall !== 1'b1) begin
      testsFailed++;
      $display("[TB] FAIL read_stall: got %b expected 1", c_stall);
    end
    for (int k = 2; k <= 5; k++) begin
      @(negedge clk);
      testsRun++;
      if (m_readM !== 1'b0 || c_ready !== 1'b0 || m_address !== 16'h0020) begin
        testsFailed++;
        $display("[TB] FAIL read_busy_R+%0d: rd=%b ready=%b addr=%h expected 0 0 0020", k, m_readM, c_ready, m_address);
      end
    end
    @(negedge clk);
    testsRun++;
    if (c_ready !== 1'b1) begin
      testsFailed++;
      $display("[TB] FAIL read_ready: got %b expected 1", c_ready);
    end
    e = (cExp.size() > 0) ? cExp.pop_front() : '{addr: 16'h0, data: 64'h0};
    testsRun++;
    if (c_rdata !== e.data) begin
      testsFailed++;
      $display("[TB] FAIL read_data: got %h expected %h", c_rdata, e.data);
    end
    testsRun++;
    if (c_stall !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL read_stall_done: got %b expected 0", c_stall);
    end
    applyStimulus(1'b0, 1'b0, 16'h0020, 64'h0);
    @(negedge clk);
    testsRun++;
    if (c_ready !== 1'b0 || c_rdata !== e.data) begin
      testsFailed++;
      $display("[TB] FAIL read_hold: ready=%b data=%h expected 0 %h", c_ready, c_rdata, e.data);
    end
  endtask

  // Both strobes high: must be handled as a write.
  task automatic test_cache_write;
    exp_t e;
    int bad;
    applyStimulus(1'b1, 1'b1, 16'h0040, 64'hAAAA_BBBB_CCCC_DDDD);
    cExp.push_back('{addr: 16'h0040, data: 64'hAAAA_BBBB_CCCC_DDDD});
    @(negedge clk);
    testsRun++;
    if (m_writeM !== 1'b1 || m_readM !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL write_issue: wr=%b rd=%b expected 1 0", m_writeM, m_readM);
    end
    bad = 0;
    for (int k = 2; k <= 6; k++) begin
      @(negedge clk);
      if (m_writeM !== 1'b0 || m_wdata !== 64'hAAAA_BBBB_CCCC_DDDD || m_address !== 16'h0040) bad++;
      if (k < 6 && c_ready !== 1'b0) bad++;
    end
    testsRun++;
    if (bad != 0) begin
      testsFailed++;
      $display("[TB] FAIL write_hold: %0d bad cycles expected 0", bad);
    end
    e = (cExp.size() > 0) ? cExp.pop_front() : '{addr: 16'h0, data: 64'h0};
    testsRun++;
    if (c_ready !== 1'b1 || m_address !== e.addr || m_wdata !== e.data) begin
      testsFailed++;
      $display("[TB] FAIL write_ready: ready=%b addr=%h data=%h expected 1 %h %h", c_ready, m_address, m_wdata, e.addr, e.data);
    end
    applyStimulus(1'b0, 1'b0, 16'h0040, 64'h0);
    @(negedge clk);
    testsRun++;
    if (m_writeM !== 1'b0 || c_ready !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL write_no_repeat: wr=%b ready=%b expected 0 0", m_writeM, c_ready);
    end
  endtask

  task automatic test_arbitration;
    exp_t e;
    int n, stallErr, bgErr;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    memData = 64'h5555_6666_7777_8888;
    applyStimulus(1'b1, 1'b0, 16'h0080, 64'h0);
    dma_br = 1'b1;
    cExp.push_back('{addr: 16'h0080, data: 64'h5555_6666_7777_8888});
    bgErr = 0;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      if (dma_bg !== 1'b0) bgErr++;
      if (k == 1) begin
        testsRun++;
        if (m_readM !== 1'b1 || m_address !== 16'h0080) begin
          testsFailed++;
          $display("[TB] FAIL arb_cache_first: rd=%b addr=%h expected 1 0080", m_readM, m_address);
        end
      end
    end
    @(negedge clk);
    e = (cExp.size() > 0) ? cExp.pop_front() : '{addr: 16'h0, data: 64'h0};
    testsRun++;
    if (c_ready !== 1'b1 || c_rdata !== e.data || dma_bg !== 1'b0 || bgErr != 0) begin
      testsFailed++;
      $display("[TB] FAIL arb_cache_done: ready=%b data=%h bg=%b bgErr=%0d expected 1 %h 0 0", c_ready, c_rdata, dma_bg, bgErr, e.data);
    end
    applyStimulus(1'b0, 1'b0, 16'h0080, 64'h0);
    @(negedge clk);
    testsRun++;
    if (dma_bg !== 1'b1 || m_readM !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL arb_grant: bg=%b rd=%b expected 1 0", dma_bg, m_readM);
    end
    memData = 64'h9999_AAAA_BBBB_CCCC;
    applyStimulus(1'b1, 1'b0, 16'h0100, 64'h0);
    cExp.push_back('{addr: 16'h0100, data: 64'h9999_AAAA_BBBB_CCCC});
    stallErr = 0;
    bgErr = 0;
    dma_writeM = 1'b1;
    for (int i = 0; i < 3; i++) begin
      dma_address = 16'h01F4 + 16'(4 * i);
      dma_wdata = {4{16'(16'h1000 + i)}};
      dExp.push_back('{addr: dma_address, data: dma_wdata});
      n = 0;
      do begin
        @(negedge clk);
        n++;
        if (c_stall !== 1'b1) stallErr++;
        if (dma_bg !== 1'b1) bgErr++;
        if (i == 2 && n == 2) dma_br = 1'b0;
      end while (dma_ready !== 1'b1 && n < 20);
      e = (dExp.size() > 0) ? dExp.pop_front() : '{addr: 16'h0, data: 64'h0};
      testsRun++;
      if (dma_ready !== 1'b1 || m_address !== e.addr || m_wdata !== e.data) begin
        testsFailed++;
        $display("[TB] FAIL dma_write_%0d: ready=%b addr=%h data=%h expected 1 %h %h", i, dma_ready, m_address, m_wdata, e.addr, e.data);
      end
    end
    testsRun++;
    if (stallErr != 0 || bgErr != 0) begin
      testsFailed++;
      $display("[TB] FAIL dma_ownership: stallErr=%0d bgErr=%0d expected 0 0", stallErr, bgErr);
    end
    dma_writeM = 1'b0;
    @(negedge clk);
    testsRun++;
    if (dma_bg !== 1'b0 || dma_ready !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL dma_release: bg=%b ready=%b expected 0 0", dma_bg, dma_ready);
    end
    @(negedge clk);
    testsRun++;
    if (m_readM !== 1'b1 || m_address !== 16'h0100) begin
      testsFailed++;
      $display("[TB] FAIL pending_cache: rd=%b addr=%h expected 1 0100", m_readM, m_address);
    end
    n = 0;
    while (c_ready !== 1'b1 && n < 10) begin
      @(negedge clk);
      n++;
    end
    e = (cExp.size() > 0) ? cExp.pop_front() : '{addr: 16'h0, data: 64'h0};
    testsRun++;
    if (c_ready !== 1'b1 || c_rdata !== e.data) begin
      testsFailed++;
      $display("[TB] FAIL pending_cache_data: ready=%b data=%h expected 1 %h", c_ready, c_rdata, e.data);
    end
    applyStimulus(1'b0, 1'b0, 16'h0, 64'h0);
    @(negedge clk);
  endtask

  task automatic test_dma_no_grant;
    exp_t e;
    int bad, n;
    dma_writeM = 1'b1;
    dma_address = 16'h0300;
    dma_wdata = 64'h0123_4567_89AB_CDEF;
    bad = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (m_writeM !== 1'b0 || dma_ready !== 1'b0 || dma_bg !== 1'b0) bad++;
    end
    testsRun++;
    if (bad != 0) begin
      testsFailed++;
      $display("[TB] FAIL dma_ungranted: %0d bad cycles expected 0", bad);
    end
    dma_writeM = 1'b0;
    dma_br = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (dma_bg !== 1'b1 && n < 5);
    memData = 64'hFEED_FACE_CAFE_BEEF;
    dma_readM = 1'b1;
    dma_address = 16'h0304;
    dExp.push_back('{addr: 16'h0304, data: 64'hFEED_FACE_CAFE_BEEF});
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (dma_ready !== 1'b1 && n < 15);
    e = (dExp.size() > 0) ? dExp.pop_front() : '{addr: 16'h0, data: 64'h0};
    testsRun++;
    if (dma_ready !== 1'b1 || n != 6 || dma_rdata !== e.data) begin
      testsFailed++;
      $display("[TB] FAIL dma_read: ready=%b cycles=%0d data=%h expected 1 6 %h", dma_ready, n, dma_rdata, e.data);
    end
    dma_readM = 1'b0;
    dma_br = 1'b0;
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset_mid;
    exp_t e;
    int bad, n;
    memData = 64'h0F0F_0F0F_0F0F_0F0F;
    applyStimulus(1'b1, 1'b0, 16'h0200, 64'h0);
    cExp.push_back('{addr: 16'h0200, data: 64'h0F0F_0F0F_0F0F_0F0F});
    repeat (3) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    testsRun++;
    if (allOutputs() !== '0) begin
      testsFailed++;
      $display("[TB] FAIL reset_mid_outputs: got %h expected 0", allOutputs());
    end
    cExp.delete();
    applyStimulus(1'b0, 1'b0, 16'h0, 64'h0);
    @(negedge clk);
    reset = 1'b0;
    bad = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (c_ready !== 1'b0 || m_readM !== 1'b0) bad++;
    end
    testsRun++;
    if (bad != 0) begin
      testsFailed++;
      $display("[TB] FAIL reset_abandon: %0d bad cycles expected 0", bad);
    end
    memData = 64'h7777_0000_7777_0000;
    applyStimulus(1'b1, 1'b0, 16'h0208, 64'h0);
    cExp.push_back('{addr: 16'h0208, data: 64'h7777_0000_7777_0000});
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (c_ready !== 1'b1 && n < 15);
    e = (cExp.size() > 0) ? cExp.pop_front() : '{addr: 16'h0, data: 64'h0};
    testsRun++;
    if (c_ready !== 1'b1 || n != 6 || c_rdata !== e.data) begin
      testsFailed++;
      $display("[TB] FAIL reset_recover: ready=%b cycles=%0d data=%h expected 1 6 %h", c_ready, n, c_rdata, e.data);
    end
    applyStimulus(1'b0, 1'b0, 16'h0, 64'h0);
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    test_reset();
    test_cache_read();
    test_cache_write();
    test_arbitration();
    test_dma_no_grant();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
